spi_slave_in: RTL and testbench



---
 rtl/spi_slave_in.sv | 99 +++++++++
 tb/tb_spi_slave_in.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_in.sv
// SPI slave receiver: oversamples SCK/CS/MOSI on clk, shifts in
// LSB-first words and emits each completed word with a valid pulse.
module spi_slave_in #(
  parameter int BITS = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            sck,
  input  logic            cs,
  input  logic            mosi,
  output logic [BITS-1:0] out_buf,
  output logic            out_valid,
  output logic            frame_err,
  output logic            busy
);

  localparam int CW = $clog2(BITS);

  logic [2:0]      meta_q;
  logic [2:0]      sync_q;
  logic            sck_prev_q;
  logic            cs_prev_q;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [BITS-2:0] sh_q, sh_d;
  logic [BITS-1:0] buf_q, buf_d;
  logic            valid_q, valid_d;
  logic            ferr_q, ferr_d;

  logic            s_sck, s_cs, s_mosi;
  logic            rise, cs_rise;
  logic [BITS-1:0] word;

  assign s_sck  = sync_q[2];
  assign s_cs   = sync_q[1];
  assign s_mosi = sync_q[0];

  // CS gating uses the delayed copy so a last SCK rise
  // coincident with CS release is still captured.
  assign rise    = s_sck & ~sck_prev_q & ~cs_prev_q;
  assign cs_rise = s_cs & ~cs_prev_q;
  assign word    = {s_mosi, sh_q};

  always_comb begin
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    buf_d   = buf_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    if (rise) begin
      sh_d = word[BITS-1:1];
      if (cnt_q == CW'(BITS - 1)) begin
        cnt_d   = '0;
        buf_d   = word;
        valid_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
    if (cs_rise) begin
      ferr_d = (cnt_d != '0);
      cnt_d  = '0;
      sh_d   = '0;
    end
    if (cs_prev_q) begin
      cnt_d = '0;
      sh_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta_q     <= 3'b111;
      sync_q     <= 3'b111;
      sck_prev_q <= 1'b1;
      cs_prev_q  <= 1'b1;
      cnt_q      <= '0;
      sh_q       <= '0;
      buf_q      <= '0;
      valid_q    <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      meta_q     <= {sck, cs, mosi};
      sync_q     <= meta_q;
      sck_prev_q <= s_sck;
      cs_prev_q  <= s_cs;
      cnt_q      <= cnt_d;
      sh_q       <= sh_d;
      buf_q      <= buf_d;
      valid_q    <= valid_d;
      ferr_q     <= ferr_d;
    end
  end

  assign out_buf   = buf_q;
  assign out_valid = valid_q;
  assign frame_err = ferr_q;
  assign busy      = ~s_cs;

endmodule

// File: tb/tb_spi_slave_in.sv
// Directed bench for spi_slave_in: queue-based receiver model
// checked every cycle, plus literal expectations per scenario.
module tb_spi_slave_in;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sck = 1'b1;
  logic        cs = 1'b1;
  logic        mosi = 1'b0;
  logic [7:0]  ob8;
  logic        ov8, fe8, bz8;
  logic [11:0] ob12;
  logic        ov12, fe12, bz12;

  spi_slave_in #(.BITS(8)) dut (
    .clk(clk), .reset(rst_n), .sck(sck), .cs(cs), .mosi(mosi),
    .out_buf(ob8), .out_valid(ov8), .frame_err(fe8), .busy(bz8)
  );

  spi_slave_in #(.BITS(12)) dut12 (
    .clk(clk), .reset(rst_n), .sck(sck), .cs(cs), .mosi(mosi),
    .out_buf(ob12), .out_valid(ov12), .frame_err(fe12), .busy(bz12)
  );

  always #5 clk = ~clk;

  int nchk = 0;
  int nerr = 0;
  int cyc = 0;
  int nvalid = 0, nferr = 0, n12 = 0, nferr12 = 0;
  int last_valid_cyc = 0;
  int drive_cyc = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t",
               name, act, exp, $time);
    end
  endtask

  // Model: raw pins sampled each edge; an SCK rise seen at edge k
  // with CS low on the previous sample shows up after edge k+2.
  bit       q_bits[$];
  bit       ph_sck, ph_cs;
  bit       qa_v, qa_f, qb_v, qb_f;
  bit [7:0] qa_w, qb_w;
  bit       m_valid, m_ferr, m_busy;
  bit [7:0] m_buf;

  always @(posedge clk or negedge rst_n) begin
    bit       rv, rf, rs;
    bit [7:0] rw;
    if (!rst_n) begin
      q_bits.delete();
      ph_sck = 1; ph_cs = 1;
      qa_v = 0; qa_f = 0; qa_w = 0;
      qb_v = 0; qb_f = 0; qb_w = 0;
      m_valid = 0; m_ferr = 0; m_busy = 0; m_buf = 0;
    end else begin
      cyc++;
      rv = 0; rf = 0; rw = 0;
      rs = sck && !ph_sck && !ph_cs;
      if (rs) begin
        q_bits.push_back(mosi);
        if (q_bits.size() == 8) begin
          for (int i = 0; i < 8; i++) rw[i] = q_bits[i];
          q_bits.delete();
          rv = 1;
        end
      end
      if (cs && !ph_cs) begin
        rf = (q_bits.size() != 0);
        q_bits.delete();
      end
      if (ph_cs) q_bits.delete();
      m_valid = qb_v;
      m_ferr  = qb_f;
      if (qb_v) m_buf = qb_w;
      m_busy  = !ph_cs;
      qb_v = qa_v; qb_f = qa_f; qb_w = qa_w;
      qa_v = rv;   qa_f = rf;   qa_w = rw;
      ph_sck = sck;
      ph_cs  = cs;
    end
  end

  always @(negedge clk) begin
    chk("valid", ov8, m_valid);
    chk("ferr", fe8, m_ferr);
    chk("busy", bz8, m_busy);
    chk("buf", ob8, m_buf);
    if (ov8 && fe8) chk("exclusive", 1, 0);
    if (ov8) begin nvalid++; last_valid_cyc = cyc; end
    if (fe8) nferr++;
    if (ov12) n12++;
    if (fe12) nferr12++;
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic cs_low();
    cs = 1'b0;
    cycles(3);
  endtask

  task automatic send_word(input logic [15:0] w, input int n,
                           input bit raise_cs);
    for (int i = 0; i < n; i++) begin
      sck = 1'b0;
      mosi = w[i];
      cycles(3);
      sck = 1'b1;
      if (i == n - 1) begin
        drive_cyc = cyc;
        if (raise_cs) cs = 1'b1;
      end
      cycles(3);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int v0, f0;
    cycles(3);
    chk("rst_buf", ob8, 8'h00);
    chk("rst_busy", bz8, 1'b0);
    rst_n = 1'b1;
    cycles(3);

    // single word
    v0 = nvalid; f0 = nferr;
    cs_low();
    send_word(16'hA5, 8, 1);
    cycles(4);
    chk("a5_buf", ob8, 8'hA5);
    chk("a5_nvalid", nvalid - v0, 1);
    chk("a5_nferr", nferr - f0, 0);
    chk("a5_lat", last_valid_cyc - drive_cyc, 3);
    chk("a5_busy", bz8, 1'b0);

    // streaming two words in one frame
    v0 = nvalid;
    cs_low();
    send_word(16'h3C, 8, 0);
    cycles(1);
    chk("s1_buf", ob8, 8'h3C);
    chk("s1_lat", last_valid_cyc - drive_cyc, 3);
    send_word(16'hFF, 8, 1);
    cycles(4);
    chk("s2_buf", ob8, 8'hFF);
    chk("s2_lat", last_valid_cyc - drive_cyc, 3);
    chk("s_nvalid", nvalid - v0, 2);

    // abort after 5 bits
    v0 = nvalid; f0 = nferr;
    cs_low();
    send_word(16'h00, 5, 0);
    cs = 1'b1;
    cycles(5);
    chk("ab_nferr", nferr - f0, 1);
    chk("ab_nvalid", nvalid - v0, 0);
    chk("ab_buf", ob8, 8'hFF);
    cs_low();
    send_word(16'h01, 8, 1);
    cycles(4);
    chk("ab_next", ob8, 8'h01);

    // SCK activity with CS high, then CS falls while SCK high
    v0 = nvalid; f0 = nferr;
    for (int i = 0; i < 8; i++) begin
      sck = 1'b0; mosi = i[0]; cycles(3);
      sck = 1'b1; cycles(3);
    end
    cs = 1'b0;
    cycles(4);
    chk("ig_nvalid", nvalid - v0, 0);
    chk("ig_nferr", nferr - f0, 0);
    send_word(16'h80, 8, 1);
    cycles(4);
    chk("ig_buf", ob8, 8'h80);
    chk("ig_nvalid2", nvalid - v0, 1);

    // async reset mid-word
    f0 = nferr;
    cs_low();
    send_word(16'h55, 4, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_buf", ob8, 8'h00);
    chk("ar_valid", ov8, 1'b0);
    chk("ar_ferr", fe8, 1'b0);
    chk("ar_busy", bz8, 1'b0);
    @(negedge clk);
    cs = 1'b1; sck = 1'b1;
    cycles(3);
    rst_n = 1'b1;
    cycles(3);
    cs_low();
    send_word(16'h0F, 8, 1);
    cycles(4);
    chk("ar_next", ob8, 8'h0F);
    chk("ar_nferr", nferr - f0, 0);

    // 12-bit instance
    rst_n = 1'b0;
    cycles(2);
    rst_n = 1'b1;
    cycles(2);
    n12 = 0; nferr12 = 0;
    cs_low();
    send_word(16'hABC, 12, 1);
    cycles(4);
    chk("b12_n", n12, 1);
    chk("b12_buf", ob12, 12'hABC);
    chk("b12_ferr", nferr12, 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
